alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have one parameter, DATA_WIDTH, default 32: operand and result width; shift amount SHALL always be operand B bits [4:0].
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 ALU_Operation_i  input  4  operation code from the ALU control unit.
REQ-005 A_i  input  DATA_WIDTH  operand A (rs1).
REQ-006 B_i  input  DATA_WIDTH  operand B (rs2 or immediate).
REQ-007 in_valid_i  input  1  operation request valid.
REQ-008 in_ready_o  output  1  block can accept a request.
REQ-009 out_valid_o  output  1  result, zero and branch outputs are valid.
REQ-010 out_ready_i  input  1  consumer accepts the result.
REQ-011 ALU_Result_o  output  DATA_WIDTH  result.
REQ-012 Zero_o  output  1  high when ALU_Result_o equals 0.
REQ-013 Branch_Taken_o  output  1  branch condition outcome.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT and DONE; in_ready_o SHALL be high only in IDLE, and out_valid_o SHALL be high only in DONE.
REQ-015 Acceptance SHALL occur in a cycle where in_valid_i and in_ready_o are both high; A_i, B_i and ALU_Operation_i SHALL be captured then, and later changes to them SHALL have no effect.
REQ-016 Codes SHALL be decoded as follows:
- 0000 ADD: A+B.
- 0001 SUB: A-B.
- 0010 LUI: result = B.
- 0011 OR.
- 0100 SLL.
- 0101 SRL (logical, zero fill).
- 0110 AND.
- 0111 XOR.
- 1000 BEQ.
- 1001 BNE.
- 1010 BLT (signed).
- 1011-1111: result 0, Branch_Taken_o 0.
REQ-017 Add and subtract SHALL wrap modulo 2^DATA_WIDTH, with no carry or overflow output.
REQ-018 For BEQ, BNE and BLT, ALU_Result_o SHALL be A-B and Branch_Taken_o SHALL be (A==B), (A!=B) or ($signed(A)<$signed(B)) respectively; for all other codes Branch_Taken_o SHALL be 0.
REQ-019 For non-shift operations, and for shifts with shamt=0, the FSM SHALL go IDLE->DONE at acceptance, and out_valid_o SHALL be high in cycle C+1, where C is the acceptance cycle.
REQ-020 For SLL and SRL with shamt s>0, the FSM SHALL go IDLE->SHIFT; it SHALL shift the captured A by exactly one bit per cycle for s cycles (C+1..C+s), go SHIFT->DONE after the s-th shift, and assert out_valid_o in cycle C+s+1.
REQ-021 The shift counter SHALL load s at acceptance and decrement once per SHIFT cycle; SHIFT->DONE SHALL occur when the counter equals 1, and the counter SHALL NOT wrap or go negative.
REQ-022 In DONE, ALU_Result_o, Zero_o and Branch_Taken_o SHALL be held stable until out_ready_i is high; DONE->IDLE SHALL occur on that edge, and in_ready_o SHALL be high in the next cycle.
REQ-023 No new request SHALL be accepted in the cycle the result is consumed (no bypass); the maximum throughput is one operation per 2 cycles.
REQ-024 in_valid_i SHALL be ignored in SHIFT and in DONE.
REQ-025 out_ready_i SHALL be ignored outside DONE.
REQ-026 Zero_o SHALL be derived from the final registered result, not from intermediate shift values.

Reset
REQ-027 When reset is high at a rising edge, the FSM SHALL enter IDLE and ALU_Result_o, Zero_o (value 0 flag registered as 0), Branch_Taken_o, out_valid_o and the shift counter SHALL all become 0.
REQ-028 A reset in SHIFT or DONE SHALL abort the operation with no result delivered; in_ready_o SHALL be high in the first cycle after reset deasserts.
REQ-029 Reset SHALL take priority over acceptance and consumption in the same cycle.

Verification
REQ-030 ADD with A=0x7FFFFFFF, B=1, out_ready_i=1 -> out_valid_o=1 in C+1, ALU_Result_o=0x80000000, Zero_o=0; then in_ready_o=1 in C+2.
REQ-031 SLL with A=0x00000001, B=31 -> out_valid_o low through C+31 and high in C+32, with ALU_Result_o=0x80000000; SRL with A=0x80000000, B=0x20 (shamt 0) -> result 0x80000000 in C+1.
REQ-032 BLT with A=0xFFFFFFFF, B=1 -> Branch_Taken_o=1; BEQ with A=B=5 -> Branch_Taken_o=1, ALU_Result_o=0, Zero_o=1; BNE with A=B=5 -> Branch_Taken_o=0.
REQ-033 Backpressure: out_ready_i=0 for 5 cycles in DONE while A_i, B_i and in_valid_i toggle -> outputs stay constant and in_ready_o stays 0; out_ready_i=1 -> IDLE next cycle.
REQ-034 Reset asserted in the 3rd SHIFT cycle of SRL with shamt 10 -> out_valid_o never asserts, all outputs are 0 after reset, and a following XOR with A=0xF0F0F0F0, B=0xFFFFFFFF returns 0x0F0F0F0F in C+1.

Source files
------------

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU with a one-bit-per-cycle shifter and valid/ready handshake
module alu_multicycle #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o,
  output logic                  Branch_Taken_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LUI = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;
  localparam logic [3:0] OP_BLT = 4'b1010;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  shl_q, shl_d;
  logic                  zero_q, zero_d;
  logic                  branch_q, branch_d;

  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] sh_next;
  logic                  alu_br;
  logic                  is_shift;
  logic [4:0]            shamt;

  // Single-cycle results; shifts only land here when shamt is zero
  always_comb begin
    shamt    = B_i[4:0];
    diff     = A_i - B_i;
    is_shift = (ALU_Operation_i == OP_SLL) || (ALU_Operation_i == OP_SRL);
    alu_res  = '0;
    alu_br   = 1'b0;
    case (ALU_Operation_i)
      OP_ADD: alu_res = A_i + B_i;
      OP_SUB: alu_res = diff;
      OP_LUI: alu_res = B_i;
      OP_OR:  alu_res = A_i | B_i;
      OP_SLL: alu_res = A_i << shamt;
      OP_SRL: alu_res = A_i >> shamt;
      OP_AND: alu_res = A_i & B_i;
      OP_XOR: alu_res = A_i ^ B_i;
      OP_BEQ: begin
        alu_res = diff;
        alu_br  = (A_i == B_i);
      end
      OP_BNE: begin
        alu_res = diff;
        alu_br  = (A_i != B_i);
      end
      OP_BLT: begin
        alu_res = diff;
        alu_br  = ($signed(A_i) < $signed(B_i));
      end
      default: begin
        alu_res = '0;
        alu_br  = 1'b0;
      end
    endcase
    sh_next = shl_q ? (sh_q << 1) : (sh_q >> 1);
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    shl_d       = shl_q;
    result_d    = result_q;
    zero_d      = zero_q;
    branch_d    = branch_q;
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (is_shift && (shamt != 5'd0)) begin
            state_d = SHIFT;
            sh_d    = A_i;
            cnt_d   = shamt;
            shl_d   = (ALU_Operation_i == OP_SLL);
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            branch_d = alu_br;
          end
        end
      end
      SHIFT: begin
        sh_d = sh_next;
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end
        // Result and zero flag are published only once the last shift is done
        if (cnt_q <= 5'd1) begin
          state_d  = DONE;
          result_d = sh_next;
          zero_d   = (sh_next == '0);
          branch_d = 1'b0;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      shl_q    <= 1'b0;
      zero_q   <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      shl_q    <= shl_d;
      zero_q   <= zero_d;
      branch_q <= branch_d;
    end
  end

  assign ALU_Result_o   = result_q;
  assign Zero_o         = zero_q;
  assign Branch_Taken_o = branch_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with directed vectors
module tb_alu_multicycle;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        br;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic        zero, branch;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  alu_multicycle #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ALU_Operation_i(op),
    .A_i            (a),
    .B_i            (b),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .ALU_Result_o   (result),
    .Zero_o         (zero),
    .Branch_Taken_o (branch)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'b0, zero}, {31'b0, e.zero});
        chk("branch", {31'b0, branch}, {31'b0, e.br});
      end
    end
  end

  // Issues one request from just after a rising edge; lat counts cycles from C to out_valid
  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic eb, input int lat, input bit consume);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    e.res = er;
    e.zero = (er == 32'd0);
    e.br = eb;
    exp_q.push_back(e);
    op = o;
    a = av;
    b = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
    n = 1;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    chk("latency", n, lat);
    if (consume) begin
      step();
      chk("in_ready_after_consume", {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    int vcount;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 4'd0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_branch", {31'b0, branch}, 32'd0);

    issue(4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1, 1'b1);
    issue(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 1'b1);
    issue(4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1, 1'b1);
    issue(4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1, 1'b1);
    issue(4'b0010, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1'b0, 1, 1'b1);
    issue(4'b0011, 32'hF0F00000, 32'h0000FFFF, 32'hF0F0FFFF, 1'b0, 1, 1'b1);
    issue(4'b0110, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1, 1'b1);
    issue(4'b0111, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 1, 1'b1);
    issue(4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 32, 1'b1);
    issue(4'b0100, 32'h00000003, 32'h00000024, 32'h00000030, 1'b0, 5, 1'b1);
    issue(4'b0101, 32'h80000000, 32'h00000020, 32'h80000000, 1'b0, 1, 1'b1);
    issue(4'b0101, 32'hF0000000, 32'h00000004, 32'h0F000000, 1'b0, 5, 1'b1);
    issue(4'b0101, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 2, 1'b1);
    issue(4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1, 1'b1);
    issue(4'b1010, 32'h00000001, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1, 1'b1);
    issue(4'b1000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1, 1'b1);
    issue(4'b1001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1, 1'b1);
    issue(4'b1001, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1, 1'b1);
    issue(4'b1011, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1, 1'b1);
    issue(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1, 1'b1);

    out_ready = 1'b0;
    issue(4'b0011, 32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 1'b0, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom;
      op = 4'($urandom);
      in_valid = ~in_valid;
      step();
      chk("bp_result", result, 32'h00FFFF00);
      chk("bp_zero", {31'b0, zero}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

    op = 4'b0101;
    a = 32'hDEADBEEF;
    b = 32'h0000000A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("srl_busy_valid", {31'b0, out_valid}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", {31'b0, zero}, 32'd0);
    chk("abort_branch", {31'b0, branch}, 32'd0);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) vcount++;
    end
    chk("abort_no_valid", vcount, 32'd0);

    issue(4'b0111, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 1, 1'b1);

    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
